dm_cache_mem_responder: RTL and testbench

- Main-memory responder on the memory side of the direct-mapped cache FSM.
- Accepts single-cycle line requests: read for allocate, write for write-back.
- Holds a line-wide backing array and returns a one-cycle ready pulse with line data after a fixed, programmable latency.
- Serves as both the synthesizable backing store in the FPGA build and the memory model in cache benches.

---
 rtl/dm_cache_mem_responder_if.sv | 26 ++
 rtl/dm_cache_mem_responder.sv | 108 ++++++++++
 tb/tb_dm_cache_mem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_mem_responder_if.sv
// rtl/dm_cache_mem_responder_if.sv - line request/response bus between cache FSM and memory responder
interface dm_cache_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  mem_req_valid;
    logic                  mem_req_rw;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [LINE_WIDTH-1:0] mem_req_data;
    logic                  mem_ready;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  busy;
    logic                  err_overrun;
    logic [31:0]           rd_count;
    logic [31:0]           wr_count;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_ready, mem_rdata, busy, err_overrun, rd_count, wr_count
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_ready, mem_rdata, busy, err_overrun, rd_count, wr_count
    );
endinterface

// File: rtl/dm_cache_mem_responder.sv
// rtl/dm_cache_mem_responder.sv - fixed-latency line-wide backing memory for the direct-mapped cache
module dm_cache_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4,
    parameter int MEM_LINES   = 4096,
    parameter int LATENCY     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    dm_cache_mem_responder_if.slave   bus
);
    localparam int IDX_W = $clog2(MEM_LINES);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t                state, state_nxt;
    logic [7:0]            cnt;
    logic                  lat_rw;
    logic [IDX_W-1:0]      lat_idx;
    logic [LINE_WIDTH-1:0] lat_data;
    logic [LINE_WIDTH-1:0] mem [0:MEM_LINES-1];

    logic                  accept;
    logic                  overrun;
    logic                  commit;
    logic                  c_rw;
    logic [IDX_W-1:0]      c_idx;
    logic [LINE_WIDTH-1:0] c_data;
    logic [IDX_W-1:0]      req_idx;
    logic                  unused_addr;

    assign unused_addr = ^bus.mem_req_addr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESPOND : WAIT;
            WAIT:    if (cnt == 8'd1) state_nxt = RESPOND;
            RESPOND: state_nxt = accept ? ((LATENCY == 1) ? RESPOND : WAIT) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_ready = (state == RESPOND);
        bus.busy      = (state != IDLE);
    end

    // With LATENCY=1 the commit happens on the acceptance edge itself, so it uses the live request.
    always_comb begin
        req_idx = bus.mem_req_addr[OFFSET_BITS +: IDX_W];
        accept  = 1'b0;
        overrun = 1'b0;
        commit  = 1'b0;
        c_rw    = lat_rw;
        c_idx   = lat_idx;
        c_data  = lat_data;
        if (!rst) begin
            accept  = bus.mem_req_valid && (state == IDLE || state == RESPOND);
            overrun = bus.mem_req_valid && (state == WAIT);
            if (LATENCY == 1) begin
                commit = accept;
                c_rw   = bus.mem_req_rw;
                c_idx  = req_idx;
                c_data = bus.mem_req_data;
            end else begin
                commit = (state == WAIT) && (cnt == 8'd1);
            end
        end
    end

    // Backing array is never reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && c_rw) mem[c_idx] <= c_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= 8'd0;
            lat_rw          <= 1'b0;
            lat_idx         <= '0;
            lat_data        <= '0;
            bus.mem_rdata   <= '0;
            bus.err_overrun <= 1'b0;
            bus.rd_count    <= 32'd0;
            bus.wr_count    <= 32'd0;
        end else begin
            if (accept) begin
                lat_rw   <= bus.mem_req_rw;
                lat_idx  <= req_idx;
                lat_data <= bus.mem_req_data;
                cnt      <= 8'(LATENCY - 1);
                if (bus.mem_req_rw) bus.wr_count <= bus.wr_count + 32'd1;
                else                bus.rd_count <= bus.rd_count + 32'd1;
            end else if (state == WAIT) begin
                cnt <= cnt - 8'd1;
            end
            if (overrun) bus.err_overrun <= 1'b1;
            if (commit)  bus.mem_rdata   <= c_rw ? c_data : mem[c_idx];
        end
    end
endmodule

// File: tb/tb_dm_cache_mem_responder.sv
// tb/tb_dm_cache_mem_responder.sv - scoreboard bench for dm_cache_mem_responder at LATENCY 4 and 1
module tb_dm_cache_mem_responder;
    typedef struct {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q4[$];
    exp_t q1[$];

    localparam logic [127:0] LA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] LB = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] LC = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] LD = 128'hFFFFFFFF_00000000_FFFFFFFF_00000001;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_cache_mem_responder_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) if4 ();
    dm_cache_mem_responder_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) if1 ();

    dm_cache_mem_responder #(.LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    dm_cache_mem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic req(input int which, input bit rw, input logic [31:0] addr,
                       input logic [127:0] data, input logic [127:0] exp, input bit expect_resp);
        exp_t e;
        if (which == 4) begin
            if4.mem_req_valid = 1'b1; if4.mem_req_rw = rw;
            if4.mem_req_addr = addr;  if4.mem_req_data = data;
            e.cyc = cyc + 4; e.data = exp;
            if (expect_resp) q4.push_back(e);
        end else begin
            if1.mem_req_valid = 1'b1; if1.mem_req_rw = rw;
            if1.mem_req_addr = addr;  if1.mem_req_data = data;
            e.cyc = cyc + 1; e.data = exp;
            if (expect_resp) q1.push_back(e);
        end
        @(negedge clk);
        if (which == 4) begin
            if4.mem_req_valid = 1'b0; if4.mem_req_data = '1; if4.mem_req_addr = '1;
        end else begin
            if1.mem_req_valid = 1'b0; if1.mem_req_data = '1; if1.mem_req_addr = '1;
        end
    endtask

    task automatic wait_ready4();
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if4.mem_ready) begin got = 1'b1; break; end
        end
        check("ready_seen", {127'd0, got}, 128'd1);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (if4.mem_ready) begin
                if (q4.size() == 0) check("unexpected_ready4", 128'd1, 128'd0);
                else begin
                    e = q4.pop_front();
                    check("rdata4", if4.mem_rdata, e.data);
                    check("ready4_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
            if (if1.mem_ready) begin
                if (q1.size() == 0) check("unexpected_ready1", 128'd1, 128'd0);
                else begin
                    e = q1.pop_front();
                    check("rdata1", if1.mem_rdata, e.data);
                    check("ready1_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    endtask

    initial begin
        if4.mem_req_valid = 1'b0; if4.mem_req_rw = 1'b0; if4.mem_req_addr = '0; if4.mem_req_data = '0;
        if1.mem_req_valid = 1'b0; if1.mem_req_rw = 1'b0; if1.mem_req_addr = '0; if1.mem_req_data = '0;
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready",  {127'd0, if4.mem_ready}, 128'd0);
        check("rst_busy",   {127'd0, if4.busy}, 128'd0);
        check("rst_rdata",  if4.mem_rdata, 128'd0);
        check("rst_err",    {127'd0, if4.err_overrun}, 128'd0);
        check("rst_rd",     128'(if4.rd_count), 128'd0);
        check("rst_wr",     128'(if4.wr_count), 128'd0);

        // Read of empty array, busy through the wait
        req(4, 1'b0, 32'h0000_0010, '0, 128'd0, 1'b1);
        check("busy_wait", {127'd0, if4.busy}, 128'd1);
        wait_ready4();
        check("busy_respond", {127'd0, if4.busy}, 128'd1);
        @(negedge clk);
        check("busy_idle", {127'd0, if4.busy}, 128'd0);
        check("rd_cnt1", 128'(if4.rd_count), 128'd1);

        // Write then read with a different byte offset
        req(4, 1'b1, 32'h0000_0020, LA, LA, 1'b1);
        wait_ready4();
        @(negedge clk);
        req(4, 1'b0, 32'h0000_002C, '0, LA, 1'b1);
        wait_ready4();
        @(negedge clk);
        check("wr_cnt1", 128'(if4.wr_count), 128'd1);
        check("rd_cnt2", 128'(if4.rd_count), 128'd2);

        // Chained write-back then allocate in the ready cycle
        req(4, 1'b1, 32'h0000_0040, LB, LB, 1'b1);
        wait_ready4();
        req(4, 1'b0, 32'h0000_0040, '0, LB, 1'b1);
        check("chain_busy", {127'd0, if4.busy}, 128'd1);
        wait_ready4();
        @(negedge clk);
        check("chain_err", {127'd0, if4.err_overrun}, 128'd0);
        check("rd_cnt3", 128'(if4.rd_count), 128'd3);
        check("wr_cnt2", 128'(if4.wr_count), 128'd2);

        // Valid during WAIT is dropped and flagged
        req(4, 1'b0, 32'h0000_0020, '0, LA, 1'b1);
        req(4, 1'b1, 32'h0000_0040, LD, LD, 1'b0);
        wait_ready4();
        repeat (6) @(negedge clk);
        check("overrun_err", {127'd0, if4.err_overrun}, 128'd1);
        check("overrun_rd", 128'(if4.rd_count), 128'd4);
        check("overrun_wr", 128'(if4.wr_count), 128'd2);
        check("rdata_hold", if4.mem_rdata, LA);

        // Upper address bits alias
        req(4, 1'b1, 32'h0001_0000, LC, LC, 1'b1);
        wait_ready4();
        @(negedge clk);
        req(4, 1'b0, 32'h0000_0000, '0, LC, 1'b1);
        wait_ready4();
        @(negedge clk);

        // Reset two cycles into a write abandons it
        req(4, 1'b1, 32'h0000_0080, LD, LD, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",  {127'd0, if4.busy}, 128'd0);
        check("midrst_rd",    128'(if4.rd_count), 128'd0);
        check("midrst_wr",    128'(if4.wr_count), 128'd0);
        check("midrst_err",   {127'd0, if4.err_overrun}, 128'd0);
        check("midrst_rdata", if4.mem_rdata, 128'd0);
        repeat (6) @(negedge clk);
        req(4, 1'b0, 32'h0000_0080, '0, 128'd0, 1'b1);
        wait_ready4();
        @(negedge clk);
        check("post_rst_rd", 128'(if4.rd_count), 128'd1);

        // LATENCY=1: reads every other cycle, then write with chained read-after-write
        req(1, 1'b0, 32'h0000_0000, '0, 128'd0, 1'b1);
        @(negedge clk);
        req(1, 1'b0, 32'h0000_0010, '0, 128'd0, 1'b1);
        @(negedge clk);
        req(1, 1'b1, 32'h0000_0010, LA, LA, 1'b1);
        req(1, 1'b0, 32'h0000_0018, '0, LA, 1'b1);
        @(negedge clk);
        check("l1_busy", {127'd0, if1.busy}, 128'd0);
        check("l1_rd", 128'(if1.rd_count), 128'd3);
        check("l1_wr", 128'(if1.wr_count), 128'd1);

        repeat (10) @(negedge clk);
        check("q4_drained", 128'(q4.size()), 128'd0);
        check("q1_drained", 128'(q1.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
